// File: rtl/ifu_fetch_if.sv
// IF/ID boundary bundle: the instruction SRAM request/response bus plus the
// fetch-to-decode handshake and the decode-stage branch redirect signals.
interface ifu_fetch_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        IFU_to_IDU_valid;
    logic        IDU_allow_in;
    logic [31:0] pc_from_IFU;
    logic [31:0] inst_from_IFU;

    logic        IDU_br_taken;
    logic        IDU_br_taken_cancel;
    logic [31:0] IDU_br_target;

    // Fetch-unit side.
    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output IFU_to_IDU_valid, pc_from_IFU, inst_from_IFU,
        input  IDU_allow_in, IDU_br_taken, IDU_br_taken_cancel, IDU_br_target
    );

    // Memory / decode side.
    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  IFU_to_IDU_valid, pc_from_IFU, inst_from_IFU,
        output IDU_allow_in, IDU_br_taken, IDU_br_taken_cancel, IDU_br_target
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: one outstanding SRAM read at a time, a one-entry
// instruction buffer toward decode, and branch redirect with in-flight squash.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input logic        clk,
    input logic        resetn,
    ifu_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_req_pc;
    logic [31:0] r_fs_pc;
    logic [31:0] r_inst_buf;
    logic        r_discard;
    logic        r_valid;

    logic        w_cancel;
    logic        w_br_stall;
    logic        w_req;
    logic [31:0] w_addr;

    assign w_cancel   = bus.IDU_br_taken_cancel;
    // A taken branch still sitting in decode means anything fetched now is wrong-path.
    assign w_br_stall = bus.IDU_br_taken && !bus.IDU_br_taken_cancel;
    assign w_req      = (r_state == S_REQ) && !w_br_stall;
    assign w_addr     = w_cancel ? bus.IDU_br_target : r_req_pc;

    assign bus.inst_sram_req    = w_req;
    assign bus.inst_sram_wr     = 1'b0;
    assign bus.inst_sram_size   = 2'b10;
    assign bus.inst_sram_addr   = w_addr;
    assign bus.IFU_to_IDU_valid = r_valid;
    assign bus.pc_from_IFU      = r_fs_pc;
    assign bus.inst_from_IFU    = r_inst_buf;

    // NOTE: every state register is updated with <= so all branches of the
    // case read the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_req_pc   <= RESET_PC;
            r_fs_pc    <= '0;
            r_inst_buf <= '0;
            r_discard  <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end

                S_REQ: begin
                    if (w_req && bus.inst_sram_addr_ok) begin
                        // An accepted request already carries the redirect target.
                        r_fs_pc   <= w_addr;
                        r_discard <= 1'b0;
                        r_state   <= S_WAIT;
                    end else if (w_cancel) begin
                        r_req_pc <= bus.IDU_br_target;
                    end
                end

                S_WAIT: begin
                    if (bus.inst_sram_data_ok) begin
                        r_discard <= 1'b0;
                        if (w_cancel) begin
                            r_req_pc <= bus.IDU_br_target;
                        end
                        if (!r_discard && !w_cancel) begin
                            r_inst_buf <= bus.inst_sram_rdata;
                            r_valid    <= 1'b1;
                            r_state    <= S_HOLD;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end else if (w_cancel) begin
                        // The response still in flight belongs to the wrong path.
                        r_discard <= 1'b1;
                        r_req_pc  <= bus.IDU_br_target;
                    end
                end

                S_HOLD: begin
                    if (w_cancel) begin
                        r_valid  <= 1'b0;
                        r_req_pc <= bus.IDU_br_target;
                        r_state  <= S_REQ;
                    end else if (bus.IDU_allow_in) begin
                        r_valid  <= 1'b0;
                        r_req_pc <= r_fs_pc + 32'd4;
                        r_state  <= S_REQ;
                    end
                end

                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
